// File: rtl/process_scheduler.sv
// Round-robin process scheduler: per-slot state and saved PC, picks the next READY
// slot after a halt/block/preempt of the running process and hands its PC to the PC mux.
module process_scheduler #(
  parameter int NUM_PROC     = 4,
  parameter int PID_W        = 2,
  parameter int ADDRESS_SIZE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    create,
  input  logic [ADDRESS_SIZE-1:0] create_pc,
  output logic                    create_ok,
  output logic                    create_full,
  input  logic                    preempt,
  input  logic                    halt_req,
  input  logic                    block_req,
  input  logic [ADDRESS_SIZE-1:0] cur_pc,
  input  logic                    wake,
  input  logic [PID_W-1:0]        wake_pid,
  output logic                    switch_valid,
  output logic [ADDRESS_SIZE-1:0] next_pc,
  output logic [PID_W-1:0]        cur_pid,
  output logic                    idle
);
  typedef enum logic [1:0] {FREE, READY, RUNNING, BLOCKED} slot_t;
  typedef enum logic [1:0] {IDLE, SELECT, RUN} fsm_t;

  fsm_t                                  state, state_nxt;
  slot_t [NUM_PROC-1:0]                  slot_st;
  logic  [NUM_PROC-1:0][ADDRESS_SIZE-1:0] saved_pc;

  // RUN events, halt > block > preempt
  logic ev_halt, ev_block, ev_preempt, ev_any;
  assign ev_halt    = (state == RUN) && halt_req;
  assign ev_block   = (state == RUN) && block_req && !halt_req;
  assign ev_preempt = (state == RUN) && preempt && !halt_req && !block_req;
  assign ev_any     = ev_halt || ev_block || ev_preempt;

  logic             any_free, any_ready;
  logic [PID_W-1:0] free_pid;
  always_comb begin
    any_free  = 1'b0;
    any_ready = 1'b0;
    free_pid  = '0;
    for (int i = NUM_PROC - 1; i >= 0; i--) begin
      if (slot_st[i] == FREE) begin
        any_free = 1'b1;
        free_pid = PID_W'(i);
      end
      if (slot_st[i] == READY) any_ready = 1'b1;
    end
  end

  // Search starts just past the current slot and ends on it, so a lone
  // preempted process is re-dispatched.
  logic             found;
  logic [PID_W-1:0] sel_pid, probe;
  always_comb begin
    found   = 1'b0;
    sel_pid = cur_pid;
    probe   = cur_pid;
    for (int k = 1; k <= NUM_PROC; k++) begin
      probe = cur_pid + PID_W'(k);
      if (!found && slot_st[probe] == READY) begin
        found   = 1'b1;
        sel_pid = probe;
      end
    end
  end

  logic dispatch;
  assign dispatch = (state == SELECT) && found;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_ready) state_nxt = SELECT;
      SELECT:  state_nxt = found ? RUN : IDLE;
      RUN:     if (ev_any) state_nxt = SELECT;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Per-slot state; the update sources are mutually exclusive by slot state.
  for (genvar i = 0; i < NUM_PROC; i++) begin : g_slot
    slot_t                   st;
    logic [ADDRESS_SIZE-1:0] pc;
    logic                    is_cur, create_hit, wake_hit, pick_hit;

    assign is_cur     = (cur_pid == PID_W'(i));
    assign create_hit = create && any_free && (free_pid == PID_W'(i));
    assign wake_hit   = wake && (wake_pid == PID_W'(i)) && (st == BLOCKED);
    assign pick_hit   = dispatch && (sel_pid == PID_W'(i));

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        st <= FREE;
        pc <= '0;
      end else if (create_hit) begin
        st <= READY;
        pc <= create_pc;
      end else if (wake_hit) begin
        st <= READY;
      end else if (pick_hit) begin
        st <= RUNNING;
      end else if (is_cur && ev_halt) begin
        st <= FREE;
      end else if (is_cur && ev_block) begin
        st <= BLOCKED;
        pc <= cur_pc;
      end else if (is_cur && ev_preempt) begin
        st <= READY;
        pc <= cur_pc;
      end
    end

    assign slot_st[i]  = st;
    assign saved_pc[i] = pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_pid      <= '0;
      next_pc      <= '0;
      switch_valid <= 1'b0;
      idle         <= 1'b1;
      create_ok    <= 1'b0;
      create_full  <= 1'b0;
    end else begin
      switch_valid <= dispatch;
      create_ok    <= create && any_free;
      create_full  <= create && !any_free;
      if (dispatch) begin
        cur_pid <= sel_pid;
        next_pc <= saved_pc[sel_pid];
        idle    <= 1'b0;
      end else if (state == SELECT) begin
        idle    <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_process_scheduler.sv
// Bench for process_scheduler: slot-table reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_process_scheduler;
  localparam int NP = 4;
  localparam int PW = 2;
  localparam int AW = 32;
  localparam int FREE = 0, READY = 1, RUNNING = 2, BLOCKED = 3;
  localparam int P_IDLE = 0, P_SEL = 1, P_RUN = 2;

  logic          clk, reset;
  logic          create, preempt, halt_req, block_req, wake;
  logic [AW-1:0] create_pc, cur_pc, next_pc;
  logic [PW-1:0] wake_pid, cur_pid;
  logic          create_ok, create_full, switch_valid, idle;

  int n_cmp = 0;
  int n_err = 0;

  // reference model
  int            m_st[NP];
  logic [AW-1:0] m_pc[NP];
  int            m_phase, m_cur;
  logic [AW-1:0] m_next;
  logic          m_sv, m_idle, m_ok, m_full;

  process_scheduler #(.NUM_PROC(NP), .PID_W(PW), .ADDRESS_SIZE(AW)) dut (
    .clk(clk), .reset(reset),
    .create(create), .create_pc(create_pc), .create_ok(create_ok), .create_full(create_full),
    .preempt(preempt), .halt_req(halt_req), .block_req(block_req), .cur_pc(cur_pc),
    .wake(wake), .wake_pid(wake_pid),
    .switch_valid(switch_valid), .next_pc(next_pc), .cur_pid(cur_pid), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int            st0[NP];
    logic [AW-1:0] pc0[NP];
    int            base, p;
    bit            found;
    if (!reset) begin
      for (int i = 0; i < NP; i++) begin
        m_st[i] = FREE;
        m_pc[i] = '0;
      end
      m_phase = P_IDLE; m_cur = 0; m_next = '0;
      m_sv = 1'b0; m_idle = 1'b1; m_ok = 1'b0; m_full = 1'b0;
      return;
    end
    st0 = m_st;
    pc0 = m_pc;
    m_sv = 1'b0; m_ok = 1'b0; m_full = 1'b0;
    if (create) begin
      found = 1'b0;
      for (int i = 0; i < NP; i++)
        if (!found && st0[i] == FREE) begin
          found = 1'b1;
          m_st[i] = READY;
          m_pc[i] = create_pc;
        end
      m_ok = found;
      m_full = !found;
    end
    if (wake && st0[wake_pid] == BLOCKED) m_st[wake_pid] = READY;
    case (m_phase)
      P_RUN: begin
        if (halt_req) begin
          m_st[m_cur] = FREE; m_phase = P_SEL;
        end else if (block_req) begin
          m_st[m_cur] = BLOCKED; m_pc[m_cur] = cur_pc; m_phase = P_SEL;
        end else if (preempt) begin
          m_st[m_cur] = READY; m_pc[m_cur] = cur_pc; m_phase = P_SEL;
        end
      end
      P_SEL: begin
        found = 1'b0;
        base = m_cur;
        for (int k = 1; k <= NP; k++) begin
          p = (base + k) % NP;
          if (!found && st0[p] == READY) begin
            found = 1'b1;
            m_st[p] = RUNNING;
            m_cur = p;
            m_next = pc0[p];
          end
        end
        if (found) begin
          m_sv = 1'b1; m_idle = 1'b0; m_phase = P_RUN;
        end else begin
          m_idle = 1'b1; m_phase = P_IDLE;
        end
      end
      default: begin
        for (int i = 0; i < NP; i++)
          if (st0[i] == READY) m_phase = P_SEL;
      end
    endcase
  endtask

  always @(posedge clk) begin
    model_step();
    #1;
    chk("m_switch_valid", AW'(switch_valid), AW'(m_sv));
    chk("m_next_pc", next_pc, m_next);
    chk("m_cur_pid", AW'(cur_pid), AW'(m_cur));
    chk("m_idle", AW'(idle), AW'(m_idle));
    chk("m_create_ok", AW'(create_ok), AW'(m_ok));
    chk("m_create_full", AW'(create_full), AW'(m_full));
  end

  task automatic clear_inputs();
    create = 1'b0; preempt = 1'b0; halt_req = 1'b0; block_req = 1'b0; wake = 1'b0;
  endtask

  task automatic step_clear();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic do_create(input string name, input logic [AW-1:0] pc, input bit expect_ok);
    create = 1'b1; create_pc = pc;
    step_clear();
    chk({name, "_ok"}, AW'(create_ok), AW'(expect_ok));
    chk({name, "_full"}, AW'(create_full), AW'(!expect_ok));
  endtask

  task automatic wait_sv(input string name, input logic [AW-1:0] pc, input int pid);
    int n = 0;
    while (!switch_valid && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk({name, "_seen"}, AW'(switch_valid), 1);
    chk({name, "_pc"}, next_pc, pc);
    chk({name, "_pid"}, AW'(cur_pid), AW'(pid));
    chk({name, "_idle"}, AW'(idle), 0);
  endtask

  task automatic no_sv(input string name, input int n);
    repeat (n) begin
      @(negedge clk);
      chk({name, "_nosw"}, AW'(switch_valid), 0);
    end
    chk({name, "_idle"}, AW'(idle), 1);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    clear_inputs();
    create_pc = '0; cur_pc = '0; wake_pid = '0;
    reset = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_idle", AW'(idle), 1);
    chk("rst_sw", AW'(switch_valid), 0);
    chk("rst_next_pc", next_pc, 0);
    chk("rst_cur_pid", AW'(cur_pid), 0);
    chk("rst_ok", AW'(create_ok), 0);
    reset = 1'b1;
    @(negedge clk);

    // first dispatch
    do_create("c100", 32'h100, 1'b1);
    wait_sv("d0", 32'h100, 0);

    // round-robin with wrap
    do_create("c200", 32'h200, 1'b1);
    do_create("c300", 32'h300, 1'b1);
    preempt = 1'b1; cur_pc = 32'h104; step_clear();
    wait_sv("pre1", 32'h200, 1);
    preempt = 1'b1; cur_pc = 32'h204; step_clear();
    wait_sv("pre2", 32'h300, 2);
    preempt = 1'b1; cur_pc = 32'h304; step_clear();
    wait_sv("pre3", 32'h104, 0);

    // full table, then halt frees slot 0
    do_create("c400", 32'h400, 1'b1);
    do_create("c500", 32'h500, 1'b0);
    halt_req = 1'b1; step_clear();
    wait_sv("halt0", 32'h204, 1);
    do_create("c600", 32'h600, 1'b1);

    // single process block / wake
    do_reset();
    @(negedge clk);
    do_create("s100", 32'h100, 1'b1);
    wait_sv("s_d0", 32'h100, 0);
    block_req = 1'b1; cur_pc = 32'h140; step_clear();
    no_sv("blk", 4);
    wake = 1'b1; wake_pid = 2'd0; step_clear();
    wait_sv("wake0", 32'h140, 0);

    // halt beats preempt; wake of a FREE slot is ignored
    do_create("c700", 32'h700, 1'b1);
    halt_req = 1'b1; preempt = 1'b1; cur_pc = 32'h999; step_clear();
    wait_sv("halt_pre", 32'h700, 1);
    wake = 1'b1; wake_pid = 2'd0; step_clear();
    halt_req = 1'b1; step_clear();
    no_sv("wake_free", 4);

    // reset while in SELECT
    do_create("r100", 32'h100, 1'b1);
    wait_sv("r_d0", 32'h100, 0);
    preempt = 1'b1; cur_pc = 32'h108; step_clear();
    reset = 1'b0;
    #1;
    chk("rsel_sw", AW'(switch_valid), 0);
    chk("rsel_idle", AW'(idle), 1);
    chk("rsel_pc", next_pc, 0);
    @(negedge clk);
    reset = 1'b1;
    no_sv("rsel", 4);

    // randomized traffic
    for (int c = 0; c < 4000; c++) begin
      create    = ($urandom_range(5) == 0);
      create_pc = $urandom;
      preempt   = ($urandom_range(4) == 0);
      halt_req  = ($urandom_range(11) == 0);
      block_req = ($urandom_range(9) == 0);
      cur_pc    = $urandom;
      wake      = ($urandom_range(3) == 0);
      wake_pid  = PW'($urandom_range(NP - 1));
      reset     = ($urandom_range(599) != 0);
      @(negedge clk);
    end
    clear_inputs();
    reset = 1'b1;
    repeat (4) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
